// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: core<->memory handshake structs,
// responder state encoding and the misaligned-access marker word.
package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef logic [1:0] dmem_state_e;
  localparam dmem_state_e IDLE = 2'd0;
  localparam dmem_state_e BUSY = 2'd1;
  localparam dmem_state_e RESP = 2'd2;

  localparam logic [31:0] dmem_err_data_gp = 32'hDEADBEEF;

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    return {24'h0, word[{lane, 3'b000} +: 8]};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM: 32-bit words, per-byte write enable, read port follows addr_i
// so the responder can capture read data into its response register at commit.
module dmem_array #(
  parameter int ADDR_WIDTH_P = 10
) (
  input  logic                    clk,
  input  logic [ADDR_WIDTH_P-1:0] addr_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH_P)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits it after LATENCY_P cycles
// and holds the response until the core yumis. DMEM_ALIGN_CHECK_EN flags misaligned word accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH_P = 10,
  parameter int LATENCY_P    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] data_mem_addr_i,
  output mem_out_s    from_mem_o,
  output logic        err_o
);

  // state | meaning
  // IDLE  | ready; yumi follows core valid, request latched on accept
  // BUSY  | latency countdown; access commits when ctr reaches 0
  // RESP  | response valid and held until core yumi

  localparam int CTR_W = (LATENCY_P > 1) ? $clog2(LATENCY_P) : 1;
  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(LATENCY_P - 1);

  dmem_state_e             state_q, state_d;
  logic [CTR_W-1:0]        ctr_q, ctr_d;
  logic [ADDR_WIDTH_P+1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wen_q, wen_d;
  logic                    bnw_q, bnw_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    accept, commit, misalign;
  logic [ADDR_WIDTH_P+1:0] acc_addr;
  logic [31:0]             acc_wdata;
  logic                    acc_wen, acc_bnw;
  logic [1:0]              lane;
  logic [ADDR_WIDTH_P-1:0] idx;
  logic [3:0]              ram_be;
  logic [31:0]             ram_wdata, ram_rdata, resp_data;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^data_mem_addr_i[31:ADDR_WIDTH_P+2];

  assign accept = (state_q == IDLE) && to_mem_i.valid;
  assign commit = ((state_q == BUSY) && (ctr_q == '0)) || ((LATENCY_P == 1) && accept);

  // With a one-cycle latency the access commits on the accept edge, before anything is latched.
  assign acc_addr  = (state_q == IDLE) ? data_mem_addr_i[ADDR_WIDTH_P+1:0] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? to_mem_i.write_data : wdata_q;
  assign acc_wen   = (state_q == IDLE) ? to_mem_i.wen : wen_q;
  assign acc_bnw   = (state_q == IDLE) ? to_mem_i.byte_not_word : bnw_q;
  assign lane      = acc_addr[1:0];
  assign idx       = acc_addr[ADDR_WIDTH_P+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign misalign = !acc_bnw && (lane != 2'b00);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= commit && misalign;
  end
  assign err_o = err_q;
`else
  assign misalign = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_comb begin
    ram_be    = 4'h0;
    ram_wdata = acc_bnw ? {4{acc_wdata[7:0]}} : acc_wdata;
    if (commit && acc_wen && !misalign) begin
      ram_be = acc_bnw ? (4'b0001 << lane) : 4'hF;
    end
  end

  always_comb begin
    resp_data = ram_rdata;
    if (acc_wen)      resp_data = 32'h0;
    else if (misalign) resp_data = dmem_err_data_gp;
    else if (acc_bnw)  resp_data = lane_extract(ram_rdata, lane);
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    rdata_d = commit ? resp_data : rdata_q;
    case (state_q)
      IDLE: begin
        if (to_mem_i.valid) begin
          addr_d  = data_mem_addr_i[ADDR_WIDTH_P+1:0];
          wdata_d = to_mem_i.write_data;
          wen_d   = to_mem_i.wen;
          bnw_d   = to_mem_i.byte_not_word;
          ctr_d   = CTR_LOAD;
          state_d = (LATENCY_P == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (ctr_q == '0) state_d = RESP;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      RESP: begin
        if (to_mem_i.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      bnw_q   <= bnw_d;
      rdata_q <= rdata_d;
    end
  end

  dmem_array #(.ADDR_WIDTH_P(ADDR_WIDTH_P)) u_array (
    .clk     (clk),
    .addr_i  (idx),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    from_mem_o           = '0;
    from_mem_o.read_data = rdata_q;
    from_mem_o.valid     = (state_q == RESP);
    from_mem_o.yumi      = accept;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random/directed bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam logic [31:0] AMASK = (32'd4 << AW) - 32'd1;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  mem_in_s     to_mem;
  logic [31:0] addr;
  mem_out_s    from_mem;
  logic        err;

  dmem_responder #(.ADDR_WIDTH_P(AW), .LATENCY_P(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .to_mem_i        (to_mem),
    .data_mem_addr_i (addr),
    .from_mem_o      (from_mem),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wen;
    bit          bnw;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
    bit          b2b;
    bit          hv;
  } stim_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          acc;
  } exp_t;

  stim_t       sq[$];
  exp_t        expq[$];
  logic [7:0]  mb [int unsigned];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [31:0] x);
    return mb.exists(x) ? mb[x] : 8'h00;
  endfunction

  // Memory seen as a flat little-endian byte space that wraps at 4<<AW bytes.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] a, base;
    a      = s.a & AMASK;
    base   = a & ~32'h3;
    e.data = 32'h0;
    e.err  = 1'b0;
    e.acc  = 0;
    if (ALIGN && !s.bnw && (a % 4) != 0) begin
      e.err  = 1'b1;
      e.data = s.wen ? 32'h0 : 32'hDEADBEEF;
      return e;
    end
    if (s.wen) begin
      if (s.bnw) mb[a] = s.wd[7:0];
      else for (int k = 0; k < 4; k++) mb[base + 32'(k)] = s.wd[8*k +: 8];
    end else if (s.bnw) begin
      e.data = {24'h0, rdb(a)};
    end else begin
      e.data = {rdb(base + 32'd3), rdb(base + 32'd2), rdb(base + 32'd1), rdb(base)};
    end
    return e;
  endfunction

  function automatic stim_t mk(input bit wen, input bit bnw, input logic [31:0] a,
                               input logic [31:0] wd, input int hold = 0,
                               input bit b2b = 1'b0, input bit hv = 1'b0);
    stim_t s;
    s.wen = wen; s.bnw = bnw; s.a = a; s.wd = wd; s.hold = hold; s.b2b = b2b; s.hv = hv;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    to_mem.valid         = 1'b1;
    to_mem.wen           = s.wen;
    to_mem.byte_not_word = s.bnw;
    to_mem.write_data    = s.wd;
    addr                 = s.a;
  endtask

  // Monitor: pops an expectation on each new response and checks stability while held.
  bit          prev_v = 1'b0;
  logic [31:0] last_d = 32'h0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else if (from_mem.valid) begin
      if (!prev_v) begin
        chk("resp_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          chk("resp_data", from_mem.read_data, mon_e.data);
          chk("resp_err", 32'(err), 32'(mon_e.err));
          chk("resp_latency", 32'(cyc - mon_e.acc), 32'(LAT));
        end
      end else begin
        chk("resp_stable", from_mem.read_data, last_d);
        chk("err_single_pulse", 32'(err), 32'd0);
      end
      last_d = from_mem.read_data;
      prev_v = 1'b1;
    end else begin
      prev_v = 1'b0;
      chk("err_idle", 32'(err), 32'd0);
    end
  end

  // Driver: called and returns at posedge+1 time.
  task automatic run_queue();
    stim_t s;
    exp_t  e;
    int    n;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      if (!to_mem.valid) begin
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      drive(s);
      n = 0;
      @(negedge clk);
      while (!from_mem.yumi && n < 20) begin n++; @(negedge clk); end
      chk("accept_wait", 32'(n), 32'd0);
      e     = model(s);
      e.acc = cyc + 1;
      expq.push_back(e);
      @(posedge clk); #1;
      if (!s.hv) to_mem.valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!from_mem.valid && n < 20) begin
        if (s.hv) chk("held_valid_no_accept", 32'(from_mem.yumi), 32'd0);
        n++;
        @(negedge clk);
      end
      chk("resp_arrived", 32'(from_mem.valid), 32'd1);
      repeat (s.hold) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_valid", 32'(from_mem.valid), 32'd1);
        if (s.hv) chk("hold_no_accept", 32'(from_mem.yumi), 32'd0);
      end
      @(posedge clk); #1;
      to_mem.yumi = 1'b1;
      if (s.b2b && sq.size() != 0) drive(sq[0]);
      else to_mem.valid = 1'b0;
      @(negedge clk);
      if (to_mem.valid) chk("resp_no_reaccept", 32'(from_mem.yumi), 32'd0);
      @(posedge clk); #1;
      to_mem.yumi = 1'b0;
    end
    to_mem.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t       s;
    exp_t        e;
    int          n;
    logic [31:0] a;
    bit          bnw;

    to_mem = '0;
    addr   = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(from_mem.valid), 32'd0);
    chk("reset_yumi", 32'(from_mem.yumi), 32'd0);
    chk("reset_data", from_mem.read_data, 32'h0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) sq.push_back(mk(1, 0, 32'h100 + 32'(i * 4), $urandom));
    sq.push_back(mk(1, 0, 32'h10, 32'h1234_5678));
    sq.push_back(mk(0, 0, 32'h10, 32'h0));
    sq.push_back(mk(1, 1, 32'h13, 32'hFFFF_FFAB));
    sq.push_back(mk(0, 0, 32'h10, 32'h0));
    sq.push_back(mk(0, 1, 32'h13, 32'h0));
    sq.push_back(mk(0, 0, 32'h10, 32'h0, 5, 1'b1, 1'b1));
    sq.push_back(mk(0, 1, 32'h12, 32'h0));
    sq.push_back(mk(1, 0, 32'h20, 32'hCAFE_F00D));
    sq.push_back(mk(1, 0, (32'd4 << AW) + 32'h8, 32'h55AA_55AA));
    sq.push_back(mk(0, 0, 32'h8, 32'h0));
    sq.push_back(mk(0, 0, 32'h11, 32'h0));
    sq.push_back(mk(1, 0, 32'h11, 32'h0BAD_F00D));
    sq.push_back(mk(0, 0, 32'h10, 32'h0));
    run_queue();
    drain();

    // Reset during BUSY of a store to 0x20: the store must not land.
    drive(mk(1, 0, 32'h20, 32'hFFFF_FFFF, 0));
    @(negedge clk);
    chk("rst_store_accept", 32'(from_mem.yumi), 32'd1);
    @(posedge clk); #1;
    to_mem.valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_busy_valid", 32'(from_mem.valid), 32'd0);
    chk("rst_busy_data", from_mem.read_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset while a response is held: outputs drop at once.
    @(posedge clk); #1;
    s = mk(0, 0, 32'h20, 32'h0);
    drive(s);
    @(negedge clk);
    chk("rst_load_accept", 32'(from_mem.yumi), 32'd1);
    e     = model(s);
    e.acc = cyc + 1;
    expq.push_back(e);
    @(posedge clk); #1;
    to_mem.valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!from_mem.valid && n < 20) begin n++; @(negedge clk); end
    chk("rst_load_resp", 32'(from_mem.valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(from_mem.valid), 32'd0);
    chk("rst_resp_data", from_mem.read_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    sq.push_back(mk(0, 0, 32'h20, 32'h0));
    for (int i = 0; i < 60; i++) begin
      bnw = ($urandom_range(0, 1) == 1);
      a   = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
      if (bnw || $urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
      a = a | (32'($urandom_range(0, 3)) << (AW + 2));
      sq.push_back(mk($urandom_range(0, 1) == 1, bnw, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1));
    end
    run_queue();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
